song_ctrl: RTL and testbench

Front-panel controller that sits directly upstream of the automatic song player. It debounces three raw push-buttons (play/stop, next, previous) and runs a small play/stop/switch state machine. It drives the player's song select and its active-low run/reset input, so every start or song change restarts playback from note 0.

---
 rtl/piano_pkg.sv | 13 +
 rtl/btn_debounce.sv | 41 ++++
 rtl/song_ctrl.sv | 81 ++++++++
 tb/tb_song_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// piano_pkg: shared FSM state, song count and clock-rate defaults for the
// front-panel controller.
package piano_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, SWITCH} state_t;
    localparam int CLK_HZ              = 100_000_000;
    localparam int DEBOUNCE_CYCLES_DEF = 2_000_000;
    localparam int GAP_CYCLES_DEF      = 10_000_000;
    localparam int NUM_SONGS_DEF       = 2;
    function automatic logic [1:0] song_step(input logic [1:0] s, input logic [1:0] last,
                                             input logic up);
        return up ? ((s == last) ? 2'd0 : s + 2'd1) : ((s == 2'd0) ? last : s - 2'd1);
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability counter and one-cycle press pulse
// for a raw push-button.
module btn_debounce
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic sync1_q, sync2_q, level_q, level_d, press_q, press_d, flip;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        flip    = (sync2_q != level_q) && (cnt_q == CNT_MAX);
        level_d = flip ? sync2_q : level_q;
        press_d = flip && sync2_q;
        cnt_d   = (sync2_q == level_q || flip) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end
    assign level = level_q;
    assign press = press_q;
endmodule

// File: rtl/song_ctrl.sv
// song_ctrl: debounced play/next/prev buttons driving a play/stop/switch FSM
// that selects the song and holds the player in reset while stopped or switching.
module song_ctrl
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int GAP_CYCLES      = GAP_CYCLES_DEF,
    parameter int NUM_SONGS       = NUM_SONGS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_play,
    input  logic       btn_next,
    input  logic       btn_prev,
    output logic [1:0] song_num,
    output logic       player_rst_n,
    output logic       playing
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);
    localparam logic [1:0] LAST = 2'(NUM_SONGS - 1);
    logic play_p, next_p, prev_p, step, nxt, prv;
    logic [1:0] song_q, song_d;
    logic [GW-1:0] gap_q, gap_d;
    logic run_q, run_d;
    state_t state_q, state_d;
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_play (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_play), .level(), .press(play_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_next), .level(), .press(next_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_prev), .level(), .press(prev_p));
    // play outranks next, next outranks prev; losers are dropped
    always_comb begin
        nxt     = next_p && !play_p;
        prv     = prev_p && !play_p && !next_p;
        step    = nxt || prv;
        state_d = state_q;
        song_d  = song_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (play_p) state_d = PLAY;
                else if (step) song_d = song_step(song_q, LAST, nxt);
            end
            PLAY: begin
                if (play_p) state_d = IDLE;
                else if (step) begin
                    song_d  = song_step(song_q, LAST, nxt);
                    gap_d   = GAP_MAX;
                    state_d = SWITCH;
                end
            end
            default: begin
                if (play_p) state_d = IDLE;
                else if (step) begin
                    song_d = song_step(song_q, LAST, nxt);
                    gap_d  = GAP_MAX;
                end else if (gap_q == '0) state_d = PLAY;
                else gap_d = gap_q - 1'b1;
            end
        endcase
        run_d = (state_d == PLAY);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            song_q  <= 2'd0;
            gap_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            gap_q   <= gap_d;
            run_q   <= run_d;
        end
    end
    assign song_num     = song_q;
    assign player_rst_n = run_q;
    assign playing      = run_q;
endmodule

// File: tb/tb_song_ctrl.sv
// tb_song_ctrl: scoreboard bench; expected output changes are queued as stimulus
// is driven and popped whenever the DUT outputs change.
module tb_song_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic btn_play = 1'b0, btn_next = 1'b0, btn_prev = 1'b0;
    logic [1:0] song_num;
    logic player_rst_n, playing;
    int checks = 0, failures = 0;
    logic [3:0] exp_q[$];
    logic [3:0] prev_o = 4'b0000;
    always #5 clk = ~clk;
    song_ctrl #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(8), .NUM_SONGS(2)) dut (
        .clk(clk), .rst_n(rst_n), .btn_play(btn_play), .btn_next(btn_next),
        .btn_prev(btn_prev), .song_num(song_num), .player_rst_n(player_rst_n),
        .playing(playing));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // outputs packed as {song_num, player_rst_n, playing}
    always @(negedge clk) begin
        logic [3:0] cur;
        cur = {song_num, player_rst_n, playing};
        if (cur !== prev_o) begin
            if (exp_q.size() == 0) chk("sb_unexpected", 32'(cur), 32'(prev_o));
            else chk("sb_out", 32'(cur), 32'(exp_q.pop_front()));
            prev_o = cur;
        end
    end
    task automatic tap(input int which, input int n);
        if (which == 0) btn_play = 1'b1;
        else if (which == 1) btn_next = 1'b1;
        else btn_prev = 1'b1;
        repeat (n) @(negedge clk);
        btn_play = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (10) @(negedge clk);
    endtask
    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_out", 32'({song_num, player_rst_n, playing}), 32'h0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("idle_out", 32'({song_num, player_rst_n, playing}), 32'h0);
        // play: outputs rise 7 cycles after the raw press
        exp_q.push_back(4'b0011);
        btn_play = 1'b1;
        n = 0;
        while (!playing && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("play_latency", 32'(n), 32'd7);
        repeat (3) @(negedge clk);
        btn_play = 1'b0;
        repeat (10) @(negedge clk);
        // next while playing: gap of exactly 8 silent cycles
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0111);
        btn_next = 1'b1;
        n = 0;
        while (player_rst_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("sw_playing", 32'(playing), 32'd0);
        chk("sw_song", 32'(song_num), 32'd1);
        n = 0;
        while (!player_rst_n && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("gap_len", 32'(n), 32'd8);
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
        exp_q.push_back(4'b0100);
        tap(0, 10);
        chk("stop_state", 32'({song_num, player_rst_n, playing}), 32'b0100);
        // wrap-around in IDLE
        exp_q.push_back(4'b0000);
        tap(1, 10);
        chk("next_wrap", 32'(song_num), 32'd0);
        exp_q.push_back(4'b0100);
        tap(2, 10);
        chk("prev_wrap", 32'(song_num), 32'd1);
        chk("prev_wrap_rst", 32'(player_rst_n), 32'd0);
        exp_q.push_back(4'b0000);
        tap(1, 10);
        chk("next_wrap2", 32'(song_num), 32'd0);
        // bouncing next: glitches of 1-3 cycles, then held
        exp_q.push_back(4'b0100);
        n = 0;
        while (n < 20) begin
            int w1, w2;
            w1 = $urandom_range(1, 3);
            w2 = $urandom_range(1, 3);
            btn_next = 1'b1;
            repeat (w1) @(negedge clk);
            btn_next = 1'b0;
            repeat (w2) @(negedge clk);
            n += w1 + w2;
        end
        chk("bounce_none", 32'(song_num), 32'd0);
        tap(1, 10);
        chk("bounce_one", 32'(song_num), 32'd1);
        exp_q.push_back(4'b0000);
        tap(1, 10);
        // simultaneous play+next in IDLE: play wins, song unchanged
        exp_q.push_back(4'b0011);
        btn_play = 1'b1;
        tap(1, 10);
        chk("simul_song", 32'(song_num), 32'd0);
        chk("simul_play", 32'(playing), 32'd1);
        // reset asserted while switching
        exp_q.push_back(4'b0100);
        btn_next = 1'b1;
        n = 0;
        while (player_rst_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("sw2_song", 32'(song_num), 32'd1);
        exp_q.push_back(4'b0000);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 32'({song_num, player_rst_n, playing}), 32'h0);
        btn_next = 1'b0;
        repeat (15) @(negedge clk);
        chk("rst_hold", 32'({song_num, player_rst_n, playing}), 32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
